neuron_mac_ctrl: RTL and testbench

NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

---
 rtl/neuron_mac_ctrl.sv | 128 ++++++++++++
 tb/tb_neuron_mac_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_ctrl.sv
// Dot-product sequencer: result = bias + sum(x[k]*w[k]), k < min(len,16).
// Ports: clk/rst_n, start/len/bias/busy/done/result, addr/x_data/w_data,
//        mul_a/mul_b/mul_p (ext multiplier), add_a/add_b/add_s (ext adder).
module neuron_mac_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  len,
  input  logic [31:0] bias,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  addr,
  input  logic [31:0] x_data,
  input  logic [31:0] w_data,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_s
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL,
    ACC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  k;
  logic [3:0]  k_nx;
  logic [4:0]  len_eff;
  logic [4:0]  len_nx;
  logic [4:0]  len_clamp;
  logic [31:0] acc;
  logic [31:0] acc_nx;
  logic [31:0] prod;
  logic [31:0] prod_nx;
  logic [31:0] res_q;
  logic [31:0] res_nx;
  logic        last;

  assign len_clamp = (len > 5'd16) ? 5'd16 : len;

  // k tops out at 15, so compare in 5 bits to cover len_eff=16.
  assign last   = ({1'b0, k} == (len_eff - 5'd1));
  assign result = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      len_eff <= '0;
      acc     <= '0;
      prod    <= '0;
      res_q   <= '0;
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      len_eff <= len_nx;
      acc     <= acc_nx;
      prod    <= prod_nx;
      res_q   <= res_nx;
    end
  end

  always_comb begin
    state_nx = state;
    k_nx     = k;
    len_nx   = len_eff;
    acc_nx   = acc;
    prod_nx  = prod;
    res_nx   = res_q;
    busy     = 1'b0;
    done     = 1'b0;
    addr     = '0;
    mul_a    = '0;
    mul_b    = '0;
    add_a    = '0;
    add_b    = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          len_nx   = len_clamp;
          acc_nx   = bias;
          k_nx     = '0;
          state_nx = (len_clamp != 5'd0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        addr     = k;
        state_nx = MUL;
      end
      MUL: begin
        busy     = 1'b1;
        mul_a    = x_data;
        mul_b    = w_data;
        prod_nx  = mul_p;
        state_nx = ACC;
      end
      ACC: begin
        busy   = 1'b1;
        add_a  = acc;
        add_b  = prod;
        acc_nx = add_s;
        if (last) begin
          state_nx = DONE;
        end else begin
          k_nx     = k + 4'd1;
          state_nx = FETCH;
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        res_nx   = acc;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Self-checking bench for neuron_mac_ctrl: directed cases plus random
// dot products checked cycle by cycle against a plain arithmetic model.
module tb_neuron_mac_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic [31:0] bias;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  addr;
  logic [31:0] x_data;
  logic [31:0] w_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_p;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_s;

  logic [31:0] xm [16];
  logic [31:0] wm [16];
  logic [31:0] exp_result;
  int          n_tests;
  int          n_fail;

  neuron_mac_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .len    (len),
    .bias   (bias),
    .busy   (busy),
    .done   (done),
    .result (result),
    .addr   (addr),
    .x_data (x_data),
    .w_data (w_data),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_p  (mul_p),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_s  (add_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mul_p = mul_a * mul_b;
  assign add_s = add_a + add_b;

  always @(posedge clk) begin
    x_data <= xm[addr];
    w_data <= wm[addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_addr"}, {28'd0, addr}, 32'd0);
    check({tag, "_mula"}, mul_a, 32'd0);
    check({tag, "_mulb"}, mul_b, 32'd0);
    check({tag, "_adda"}, add_a, 32'd0);
    check({tag, "_addb"}, add_b, 32'd0);
    check({tag, "_res"}, result, 32'd0);
  endtask

  // Called right after a negedge; start is seen by the next posedge.
  // ign1/ign2: cycle offsets (from accept) at which start is re-pulsed.
  task automatic run_op(input string tag,
                        input logic [4:0] l,
                        input logic [31:0] b,
                        input int ign1,
                        input int ign2,
                        input bit scr);
    int le;
    int nlast;
    int m;
    int t;
    int ph;
    logic [31:0] acc_m;
    logic [31:0] p;
    le    = (l > 5'd16) ? 16 : int'(l);
    nlast = 3 * le + 1;
    acc_m = b;
    p     = '0;
    start = 1'b1;
    len   = l;
    bias  = b;
    for (int n = 1; n <= nlast; n++) begin
      @(negedge clk);
      m  = n - 1;
      t  = m / 3;
      ph = m % 3;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_done"}, {31'd0, done}, {31'd0, n == nlast});
      check({tag, "_res_hold"}, result, exp_result);
      if (n < nlast && ph == 0)
        check({tag, "_addr"}, {28'd0, addr}, t);
      else
        check({tag, "_addr"}, {28'd0, addr}, 32'd0);
      if (n < nlast && ph == 1) begin
        p = xm[t] * wm[t];
        check({tag, "_mula"}, mul_a, xm[t]);
        check({tag, "_mulb"}, mul_b, wm[t]);
      end else begin
        check({tag, "_mula"}, mul_a, 32'd0);
        check({tag, "_mulb"}, mul_b, 32'd0);
      end
      if (n < nlast && ph == 2) begin
        check({tag, "_adda"}, add_a, acc_m);
        check({tag, "_addb"}, add_b, p);
        acc_m = acc_m + p;
      end else begin
        check({tag, "_adda"}, add_a, 32'd0);
        check({tag, "_addb"}, add_b, 32'd0);
      end
      start = (n == ign1 || n == ign2);
      if (scr) begin
        len  = 5'($urandom);
        bias = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0;
    exp_result = acc_m;
    check({tag, "_result"}, result, acc_m);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
      check({tag, "_idle_res"}, result, acc_m);
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp_result = '0;
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    bias       = '0;
    for (int i = 0; i < 16; i++) begin
      xm[i] = '0;
      wm[i] = '0;
    end
    #2;
    check_zero_outs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    xm[0] = 1; xm[1] = 2; xm[2] = 3;
    wm[0] = 4; wm[1] = 5; wm[2] = 6;
    run_op("basic", 5'd3, 32'd10, 0, 0, 1'b0);
    check("basic_42", result, 32'd42);

    run_op("zero", 5'd0, 32'd7, 0, 0, 1'b0);
    check("zero_7", result, 32'd7);

    for (int i = 0; i < 16; i++) begin
      xm[i] = 1;
      wm[i] = i;
    end
    run_op("clamp", 5'd31, 32'd0, 0, 0, 1'b0);
    check("clamp_120", result, 32'd120);

    xm[0] = 1; xm[1] = 2; xm[2] = 3;
    wm[0] = 4; wm[1] = 5; wm[2] = 6;
    run_op("ignore", 5'd3, 32'd10, 5, 10, 1'b0);
    check("ignore_42", result, 32'd42);

    xm[0] = 32'hFFFF_FFFF;
    wm[0] = 32'd2;
    run_op("wrap", 5'd1, 32'd3, 0, 0, 1'b1);
    check("wrap_1", result, 32'd1);

    for (int i = 0; i < 4; i++) begin
      xm[i] = i + 1;
      wm[i] = i + 2;
    end
    start = 1'b1;
    len   = 5'd4;
    bias  = 32'd5;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_adda", add_a, 32'd5 + 32'd2 + 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero_outs("rsthold");
    end
    rst_n      = 1'b1;
    exp_result = '0;
    xm[0] = 3;
    wm[0] = 3;
    run_op("post_rst", 5'd1, 32'd1, 0, 0, 1'b0);
    check("post_rst_10", result, 32'd10);

    for (int r = 0; r < 20; r++) begin
      int le;
      int i1;
      logic [4:0] l;
      l  = 5'($urandom_range(0, 31));
      le = (l > 5'd16) ? 16 : int'(l);
      for (int i = 0; i < 16; i++) begin
        xm[i] = $urandom;
        wm[i] = $urandom;
      end
      i1 = (le > 0) ? int'($urandom_range(1, 3 * le)) : 0;
      run_op("rand", l, $urandom, i1, 3 * le + 1, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
